// File: rtl/afu_issue_pkg.sv
// Shared types and sizes for the EXE-stage ALU issue path.
// Holds operand widths, ALU op/select encodings and the ID->EXE issue bundle.
package afu_issue_pkg;

    localparam int RSZ        = 32;
    localparam int PC_SZ      = 32;
    localparam int AFU_CNT_SZ = 32;
    localparam int RA_SZ      = 5;

    typedef enum logic [3:0] {
        A_ADD, A_SUB, A_SLL, A_SRL, A_SRA,
        A_AND, A_OR,  A_XOR, A_SLT, A_SLTU
    } ALU_OP_TYPE;

    typedef enum logic [1:0] {
        AM_RS1, AM_RS2, AM_IMM, AM_PC
    } ALU_SEL_TYPE;

    typedef struct packed {
        logic [RSZ-1:0]   Rs1_data;
        logic [RSZ-1:0]   Rs2_data;
        logic [RSZ-1:0]   imm;
        logic [PC_SZ-1:0] pc;
        ALU_SEL_TYPE      sel_x;
        ALU_SEL_TYPE      sel_y;
        ALU_OP_TYPE       op;
        logic [RA_SZ-1:0] rs1_addr;
        logic [RA_SZ-1:0] rs2_addr;
        logic [RA_SZ-1:0] rd_addr;
    } AFU_ISSUE_TYPE;

    // x0 is hard-wired zero, so it never takes a forwarded value.
    function automatic logic fwd_hit(
        input logic             b_valid,
        input logic [RA_SZ-1:0] b_rd,
        input logic [RA_SZ-1:0] src
    );
        return b_valid && (b_rd != '0) && (src == b_rd);
    endfunction

endpackage

// File: rtl/AFU_intf.sv
// Bus between the EXE issue controller (master) and the ALU functional unit (slave).
// Master drives operands, selects and op; slave returns Rd_data combinationally.
interface AFU_intf;
    import afu_issue_pkg::*;

    logic [RSZ-1:0]   Rs1_data;
    logic [RSZ-1:0]   Rs2_data;
    logic [RSZ-1:0]   imm;
    logic [PC_SZ-1:0] pc;
    ALU_SEL_TYPE      sel_x;
    ALU_SEL_TYPE      sel_y;
    ALU_OP_TYPE       op;
    logic [RSZ-1:0]   Rd_data;

    modport master (
        output Rs1_data, Rs2_data, imm, pc, sel_x, sel_y, op,
        input  Rd_data
    );

    modport slave (
        input  Rs1_data, Rs2_data, imm, pc, sel_x, sel_y, op,
        output Rd_data
    );

endinterface

// File: rtl/afu_fwd_mux.sv
// Per-operand bypass from result register B into the ALU operand path.
// Ports: B valid/rd/data, source reg addr/data in; selected operand out. Exists only with ALU_FWD_EN.
`ifdef ALU_FWD_EN
module afu_fwd_mux
    import afu_issue_pkg::*;
(
    input  logic             b_valid,
    input  logic [RA_SZ-1:0] b_rd_addr,
    input  logic [RSZ-1:0]   b_rd_data,
    input  logic [RA_SZ-1:0] src_addr,
    input  logic [RSZ-1:0]   src_data,
    output logic [RSZ-1:0]   fwd_data
);

    always_comb begin
        fwd_data = src_data;
        if (fwd_hit(b_valid, b_rd_addr, src_addr)) begin
            fwd_data = b_rd_data;
        end
    end

endmodule
`endif

// File: rtl/afu_issue.sv
// EXE-stage ALU issue controller: ID op -> register A -> ALU bus -> result register B -> MEM/WB.
// Ports: clk_in, reset_in (sync, high), flush; id_valid/id_rdy/id_info; afu_bus (AFU_intf.master);
// exe_valid/exe_rdy/exe_rd_addr/exe_rd_data; alu_cnt. Optional B->A forwarding under ALU_FWD_EN.
module afu_issue
    import afu_issue_pkg::*;
#(
    parameter int CNT_SZ = AFU_CNT_SZ
)(
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_rdy,
    input  AFU_ISSUE_TYPE     id_info,
    AFU_intf.master           afu_bus,
    output logic              exe_valid,
    input  logic              exe_rdy,
    output logic [RA_SZ-1:0]  exe_rd_addr,
    output logic [RSZ-1:0]    exe_rd_data,
    output logic [CNT_SZ-1:0] alu_cnt
);

    logic              a_valid_q, a_valid_d;
    AFU_ISSUE_TYPE     a_q, a_d;
    logic              b_valid_q, b_valid_d;
    logic [RA_SZ-1:0]  b_rd_addr_q, b_rd_addr_d;
    logic [RSZ-1:0]    b_rd_data_q, b_rd_data_d;
    logic [CNT_SZ-1:0] cnt_q, cnt_d;

    logic b_take;
    logic b_load;
    logic accept;

    logic [RSZ-1:0] rs1_data;
    logic [RSZ-1:0] rs2_data;

    assign b_take = b_valid_q & exe_rdy;
    assign b_load = a_valid_q & (~b_valid_q | b_take);
    assign id_rdy = ~a_valid_q | b_load;
    assign accept = id_valid & id_rdy;

`ifdef ALU_FWD_EN
    afu_fwd_mux u_fwd_rs1 (
        .b_valid   (b_valid_q),
        .b_rd_addr (b_rd_addr_q),
        .b_rd_data (b_rd_data_q),
        .src_addr  (a_q.rs1_addr),
        .src_data  (a_q.Rs1_data),
        .fwd_data  (rs1_data)
    );

    afu_fwd_mux u_fwd_rs2 (
        .b_valid   (b_valid_q),
        .b_rd_addr (b_rd_addr_q),
        .b_rd_data (b_rd_data_q),
        .src_addr  (a_q.rs2_addr),
        .src_data  (a_q.Rs2_data),
        .fwd_data  (rs2_data)
    );
`else
    // Without bypass ID resolves hazards, so source addresses are dead here.
    logic fwd_unused;
    assign fwd_unused = ^{a_q.rs1_addr, a_q.rs2_addr};
    assign rs1_data   = a_q.Rs1_data;
    assign rs2_data   = a_q.Rs2_data;
`endif

    assign afu_bus.Rs1_data = rs1_data;
    assign afu_bus.Rs2_data = rs2_data;
    assign afu_bus.imm      = a_q.imm;
    assign afu_bus.pc       = a_q.pc;
    assign afu_bus.sel_x    = a_q.sel_x;
    assign afu_bus.sel_y    = a_q.sel_y;
    assign afu_bus.op       = a_q.op;

    assign exe_valid   = b_valid_q;
    assign exe_rd_addr = b_rd_addr_q;
    assign exe_rd_data = b_rd_data_q;
    assign alu_cnt     = cnt_q;

    always_comb begin
        a_valid_d   = a_valid_q;
        a_d         = a_q;
        b_valid_d   = b_valid_q;
        b_rd_addr_d = b_rd_addr_q;
        b_rd_data_d = b_rd_data_q;
        cnt_d       = cnt_q;

        // A take still counts under flush: downstream already has it.
        if (b_take) begin
            cnt_d = cnt_q + CNT_SZ'(1);
        end

        if (flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end else begin
            if (b_load) begin
                b_valid_d   = 1'b1;
                b_rd_addr_d = a_q.rd_addr;
                b_rd_data_d = afu_bus.Rd_data;
            end else if (b_take) begin
                b_valid_d = 1'b0;
            end

            if (accept) begin
                a_valid_d = 1'b1;
                a_d       = id_info;
            end else if (b_load) begin
                a_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            a_valid_q   <= 1'b0;
            a_q         <= '0;
            b_valid_q   <= 1'b0;
            b_rd_addr_q <= '0;
            b_rd_data_q <= '0;
            cnt_q       <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_q         <= a_d;
            b_valid_q   <= b_valid_d;
            b_rd_addr_q <= b_rd_addr_d;
            b_rd_data_q <= b_rd_data_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_afu_issue.sv
// Directed bench for afu_issue with a behavioural ALU on the AFU bus.
// Counter width is narrowed so the wrap case is reachable in a short run.
module tb_afu_issue;
    import afu_issue_pkg::*;

    localparam int CW = 4;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic              flush;
    logic              id_valid;
    logic              id_rdy;
    AFU_ISSUE_TYPE     id_info;
    logic              exe_valid;
    logic              exe_rdy;
    logic [RA_SZ-1:0]  exe_rd_addr;
    logic [RSZ-1:0]    exe_rd_data;
    logic [CW-1:0]     alu_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    AFU_intf afu_bus_if ();

    always #5 clk_in = ~clk_in;

    afu_issue #(.CNT_SZ(CW)) dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_rdy      (id_rdy),
        .id_info     (id_info),
        .afu_bus     (afu_bus_if),
        .exe_valid   (exe_valid),
        .exe_rdy     (exe_rdy),
        .exe_rd_addr (exe_rd_addr),
        .exe_rd_data (exe_rd_data),
        .alu_cnt     (alu_cnt)
    );

    // Behavioural ALU functional unit
    logic [RSZ-1:0] alu_x, alu_y;
    always_comb begin
        alu_x = '0;
        alu_y = '0;
        case (afu_bus_if.sel_x)
            AM_RS1:  alu_x = afu_bus_if.Rs1_data;
            AM_RS2:  alu_x = afu_bus_if.Rs2_data;
            AM_IMM:  alu_x = afu_bus_if.imm;
            default: alu_x = afu_bus_if.pc;
        endcase
        case (afu_bus_if.sel_y)
            AM_RS1:  alu_y = afu_bus_if.Rs1_data;
            AM_RS2:  alu_y = afu_bus_if.Rs2_data;
            AM_IMM:  alu_y = afu_bus_if.imm;
            default: alu_y = afu_bus_if.pc;
        endcase
        case (afu_bus_if.op)
            A_ADD:   afu_bus_if.Rd_data = alu_x + alu_y;
            A_SUB:   afu_bus_if.Rd_data = alu_x - alu_y;
            A_SLL:   afu_bus_if.Rd_data = alu_x << alu_y[4:0];
            A_SRL:   afu_bus_if.Rd_data = alu_x >> alu_y[4:0];
            A_SRA:   afu_bus_if.Rd_data = $signed(alu_x) >>> alu_y[4:0];
            A_AND:   afu_bus_if.Rd_data = alu_x & alu_y;
            A_OR:    afu_bus_if.Rd_data = alu_x | alu_y;
            A_XOR:   afu_bus_if.Rd_data = alu_x ^ alu_y;
            A_SLT:   afu_bus_if.Rd_data = {31'd0, $signed(alu_x) < $signed(alu_y)};
            default: afu_bus_if.Rd_data = {31'd0, alu_x < alu_y};
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic AFU_ISSUE_TYPE mk(
        input ALU_OP_TYPE op, input ALU_SEL_TYPE sx, input ALU_SEL_TYPE sy,
        input logic [RSZ-1:0] r1, input logic [RSZ-1:0] r2,
        input logic [RSZ-1:0] im, input logic [4:0] a1,
        input logic [4:0] a2, input logic [4:0] rd
    );
        AFU_ISSUE_TYPE t;
        t          = '0;
        t.op       = op;
        t.sel_x    = sx;
        t.sel_y    = sy;
        t.Rs1_data = r1;
        t.Rs2_data = r2;
        t.imm      = im;
        t.rs1_addr = a1;
        t.rs2_addr = a2;
        t.rd_addr  = rd;
        return t;
    endfunction

    // Issue one op with exe_rdy=1 and wait until its result has been taken.
    task automatic issue_one(input AFU_ISSUE_TYPE op,
                             output logic [RSZ-1:0] d,
                             output logic [4:0] a);
        int n;
        d = '0;
        a = '0;
        @(negedge clk_in);
        id_valid = 1'b1;
        id_info  = op;
        exe_rdy  = 1'b1;
        flush    = 1'b0;
        #1;
        n = 0;
        while (!id_rdy && n < 20) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        check("issue_rdy", id_rdy, 1);
        @(negedge clk_in);
        id_valid = 1'b0;
        #1;
        n = 0;
        while (!exe_valid && n < 20) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        check("issue_done", exe_valid, 1);
        d = exe_rd_data;
        a = exe_rd_addr;
        @(negedge clk_in);
    endtask

    AFU_ISSUE_TYPE   s_ops [4];
    logic [RSZ-1:0]  s_exp [4];
    logic [RSZ-1:0]  rd_d;
    logic [4:0]      rd_a;
    int              idx, tk, cyc;

    initial begin
        reset_in = 1'b1;
        flush    = 1'b0;
        id_valid = 1'b0;
        id_info  = '0;
        exe_rdy  = 1'b0;

        // 1. reset state
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
        #1;
        check("rst_id_rdy", id_rdy, 1);
        check("rst_exe_valid", exe_valid, 0);
        check("rst_rd_data", exe_rd_data, 0);
        check("rst_rd_addr", exe_rd_addr, 0);
        check("rst_cnt", alu_cnt, 0);

        // 2. single op, exact latency
        @(negedge clk_in);
        id_valid = 1'b1;
        id_info  = mk(A_ADD, AM_RS1, AM_IMM, 5, 0, 7, 1, 0, 3);
        exe_rdy  = 1'b1;
        #1;
        check("t2_id_rdy", id_rdy, 1);
        @(negedge clk_in);
        id_valid = 1'b0;
        #1;
        check("t2_not_yet", exe_valid, 0);
        @(negedge clk_in);
        #1;
        check("t2_valid", exe_valid, 1);
        check("t2_data", exe_rd_data, 12);
        check("t2_addr", exe_rd_addr, 3);
        @(negedge clk_in);
        #1;
        check("t2_cnt", alu_cnt, 1);
        check("t2_drained", exe_valid, 0);

        // 3. stream of 4 SUBs, downstream stalled for 3 cycles
        for (int i = 0; i < 4; i++) begin
            s_ops[i] = mk(A_SUB, AM_RS1, AM_RS2, 32'((i + 1) * 10),
                          32'(i + 1), 0, 0, 0, 5'(i + 1));
        end
        s_exp[0] = 9;
        s_exp[1] = 18;
        s_exp[2] = 27;
        s_exp[3] = 36;
        idx = 0;
        tk  = 0;
        cyc = 0;
        while (tk < 4 && cyc < 40) begin
            @(negedge clk_in);
            exe_rdy  = (cyc >= 3);
            id_valid = (idx < 4);
            id_info  = (idx < 4) ? s_ops[idx] : '0;
            #1;
            if (cyc == 2) begin
                check("t3_stall_rdy", id_rdy, 0);
                check("t3_accepts", idx, 2);
            end
            if (exe_valid && exe_rdy) begin
                check("t3_data", exe_rd_data, s_exp[tk]);
                check("t3_addr", exe_rd_addr, tk + 1);
                tk++;
            end
            if (id_valid && id_rdy) idx++;
            cyc++;
        end
        check("t3_taken", tk, 4);
        @(negedge clk_in);
        id_valid = 1'b0;
        #1;
        check("t3_no_repeat", exe_valid, 0);
        check("t3_cnt", alu_cnt, 5);

        // 4a. flush with A and B full, no take
        exe_rdy  = 1'b0;
        id_valid = 1'b1;
        id_info  = mk(A_ADD, AM_RS1, AM_RS2, 1, 1, 0, 0, 0, 5);
        @(negedge clk_in);
        id_info  = mk(A_ADD, AM_RS1, AM_RS2, 2, 2, 0, 0, 0, 6);
        @(negedge clk_in);
        id_info  = mk(A_ADD, AM_RS1, AM_RS2, 3, 3, 0, 0, 0, 7);
        #1;
        check("t4_full_valid", exe_valid, 1);
        check("t4_full_rdy", id_rdy, 0);
        flush = 1'b1;
        @(negedge clk_in);
        flush    = 1'b0;
        id_valid = 1'b0;
        #1;
        check("t4_flush_valid", exe_valid, 0);
        check("t4_flush_rdy", id_rdy, 1);
        check("t4_flush_cnt", alu_cnt, 5);
        @(negedge clk_in);
        #1;
        check("t4_no_leak", exe_valid, 0);

        // 4b. flush together with a take: take is counted
        id_valid = 1'b1;
        id_info  = mk(A_ADD, AM_RS1, AM_RS2, 4, 4, 0, 0, 0, 8);
        @(negedge clk_in);
        id_valid = 1'b0;
        @(negedge clk_in);
        #1;
        check("t4b_valid", exe_valid, 1);
        flush   = 1'b1;
        exe_rdy = 1'b1;
        @(negedge clk_in);
        flush = 1'b0;
        #1;
        check("t4b_valid_after", exe_valid, 0);
        check("t4b_cnt", alu_cnt, 6);

        // 5. back-to-back dependent ops (forwarding case)
        id_valid = 1'b1;
        id_info  = mk(A_ADD, AM_RS1, AM_RS2, 1, 2, 0, 1, 2, 4);
        @(negedge clk_in);
        id_info  = mk(A_SLL, AM_RS1, AM_IMM, 0, 0, 2, 4, 0, 7);
        #1;
        check("t5_rdy2", id_rdy, 1);
        @(negedge clk_in);
        id_valid = 1'b0;
        #1;
        check("t5_op1_data", exe_rd_data, 3);
        check("t5_op1_addr", exe_rd_addr, 4);
        @(negedge clk_in);
        #1;
        check("t5_op2_valid", exe_valid, 1);
`ifdef ALU_FWD_EN
        check("t5_op2_data", exe_rd_data, 12);
`else
        check("t5_op2_data", exe_rd_data, 0);
`endif
        check("t5_op2_addr", exe_rd_addr, 7);
        @(negedge clk_in);
        #1;
        check("t5_cnt", alu_cnt, 8);

        // 6. counter wrap at 2^CW-1
        for (int i = 0; i < 7; i++) begin
            issue_one(mk(A_ADD, AM_RS1, AM_IMM, 32'(i), 0, 100, 0, 0,
                         5'(i + 1)), rd_d, rd_a);
            check("t6_data", rd_d, i + 100);
            check("t6_addr", rd_a, i + 1);
        end
        #1;
        check("t6_cnt_max", alu_cnt, 15);
        issue_one(mk(A_XOR, AM_RS1, AM_RS2, 32'hF0, 32'hFF, 0, 0, 0, 9),
                  rd_d, rd_a);
        check("t6_xor", rd_d, 32'h0F);
        #1;
        check("t6_cnt_wrap", alu_cnt, 0);

        // 7. reset with an op in flight
        @(negedge clk_in);
        exe_rdy  = 1'b0;
        id_valid = 1'b1;
        id_info  = mk(A_OR, AM_RS1, AM_RS2, 1, 2, 0, 0, 0, 10);
        @(negedge clk_in);
        id_valid = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        #1;
        check("t7_valid", exe_valid, 0);
        check("t7_data", exe_rd_data, 0);
        check("t7_rdy", id_rdy, 1);
        check("t7_cnt", alu_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
